// File: rtl/keycode_cmd_decoder_if.sv
// Command event handshake between keycode_cmd_decoder and the game logic.
// The master drives one queued event (code + auto-repeat flag) and the slave
// accepts it with cmd_ready.
interface keycode_cmd_decoder_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    logic       cmd_repeat;

    modport master (output cmd_valid, output cmd_code, output cmd_repeat, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, input cmd_repeat, output cmd_ready);
endinterface

// File: rtl/keycode_cmd_decoder.sv
// Keycode-to-command decoder: registers the raw HID keycode, maps it to a
// game command, debounces it, and queues one event per press (plus optional
// auto-repeat events) in a small FIFO towards the game logic.
// Optional feature macro: KEYCODE_AUTOREPEAT_EN (auto-repeat FSM and counter).
//
// state       | meaning
// IDLE        | no repeatable key held, no repeat events pending
// HELD_DELAY  | repeatable key committed, waiting for the first repeat
// HELD_REPEAT | emitting repeat events every REPEAT_PERIOD cycles
module keycode_cmd_decoder #(
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          MAX10_CLK1_50,
    input  logic                          Reset_h,
    input  logic [7:0]                    keycode,
    keycode_cmd_decoder_if.master         cmd,
    output logic [2:0]                    key_held,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [2:0] CMD_PAUSE   = 3'd6;
    localparam logic [2:0] CMD_RESTART = 3'd7;

    function automatic logic [2:0] map_key(input logic [7:0] k);
        case (k)
            8'h1A:   map_key = 3'd1;
            8'h16:   map_key = 3'd2;
            8'h04:   map_key = 3'd3;
            8'h07:   map_key = 3'd4;
            8'h2C:   map_key = 3'd5;
            8'h13:   map_key = 3'd6;
            8'h15:   map_key = 3'd7;
            default: map_key = 3'd0;
        endcase
    endfunction

    logic [7:0]    key_r;
    logic [2:0]    key_map;
    logic [2:0]    cand;
    logic [SW-1:0] stab_cnt;
    logic          commit;

    logic          ev_valid;
    logic [2:0]    ev_code;

    logic [2:0]    mem_code [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign key_map = map_key(key_r);
    // Commit needs the candidate stable for the full window and still matching now.
    assign commit  = (stab_cnt == S_LAST) && (key_map == cand) && (cand != key_held);

    // Input register and debounce candidate/stability counter.
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            key_r    <= 8'h00;
            cand     <= 3'd0;
            stab_cnt <= '0;
        end else begin
            key_r <= keycode;
            if (key_map != cand) begin
                cand     <= key_map;
                stab_cnt <= '0;
            end else if (stab_cnt != S_LAST) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

`ifdef KEYCODE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] D_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] P_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HELD_DELAY, HELD_REPEAT} rpt_state_t;
    rpt_state_t    state;
    logic [RW-1:0] rpt_cnt;
    logic          ev_repeat;
    logic          mem_rep [FIFO_DEPTH];

    // Commit handling, press events and the auto-repeat FSM; a commit always wins.
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            key_held  <= 3'd0;
            ev_valid  <= 1'b0;
            ev_code   <= 3'd0;
            ev_repeat <= 1'b0;
            state     <= IDLE;
            rpt_cnt   <= '0;
        end else begin
            ev_valid  <= 1'b0;
            ev_repeat <= 1'b0;
            if (commit) begin
                key_held <= cand;
                ev_valid <= (cand != 3'd0);
                ev_code  <= cand;
                rpt_cnt  <= '0;
                if (cand == 3'd0 || cand == CMD_PAUSE || cand == CMD_RESTART)
                    state <= IDLE;
                else
                    state <= HELD_DELAY;
            end else begin
                case (state)
                    HELD_DELAY: begin
                        if (rpt_cnt == D_LAST) begin
                            ev_valid  <= 1'b1;
                            ev_code   <= key_held;
                            ev_repeat <= 1'b1;
                            rpt_cnt   <= '0;
                            state     <= HELD_REPEAT;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                    HELD_REPEAT: begin
                        if (rpt_cnt == P_LAST) begin
                            ev_valid  <= 1'b1;
                            ev_code   <= key_held;
                            ev_repeat <= 1'b1;
                            rpt_cnt   <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                    default: rpt_cnt <= '0;
                endcase
            end
        end
    end

    // Repeat flag storage alongside the command codes.
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_rep[i] <= 1'b0;
        end else if (push) begin
            mem_rep[wr_ptr] <= ev_repeat;
        end
    end

    assign cmd.cmd_repeat = empty ? 1'b0 : mem_rep[rd_ptr];
`else
    // Commit handling and press events only; no repeat machinery.
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            key_held <= 3'd0;
            ev_valid <= 1'b0;
            ev_code  <= 3'd0;
        end else begin
            ev_valid <= 1'b0;
            if (commit) begin
                key_held <= cand;
                ev_valid <= (cand != 3'd0);
                ev_code  <= cand;
            end
        end
    end

    assign cmd.cmd_repeat = 1'b0;
`endif

    assign empty = (fifo_count == '0);
    assign full  = (fifo_count == CW'(FIFO_DEPTH));
    assign pop   = cmd.cmd_valid & cmd.cmd_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still take the event.
    assign push  = ev_valid & (~full | pop);

    // Event FIFO: storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_code[i] <= 3'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem_code[wr_ptr] <= ev_code;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
            if (ev_valid && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign cmd.cmd_valid = ~empty;
    assign cmd.cmd_code  = empty ? 3'd0 : mem_code[rd_ptr];
endmodule

// File: tb/tb_keycode_cmd_decoder.sv
// Self-checking bench for keycode_cmd_decoder: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
// Expectations follow KEYCODE_AUTOREPEAT_EN when it is defined.
module tb_keycode_cmd_decoder;
    localparam int S = 4;
    localparam int D = 20;
    localparam int P = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keycode;
    logic [2:0] key_held;
    logic       overflow;
    logic [2:0] fifo_count;

    keycode_cmd_decoder_if cmd_if();

    keycode_cmd_decoder #(
        .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .FIFO_DEPTH(DEPTH)
    ) dut (
        .MAX10_CLK1_50(clk), .Reset_h(rst), .keycode(keycode), .cmd(cmd_if),
        .key_held(key_held), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int map_of(input logic [7:0] k);
        case (k)
            8'h1A: return 1;
            8'h16: return 2;
            8'h04: return 3;
            8'h07: return 4;
            8'h2C: return 5;
            8'h13: return 6;
            8'h15: return 7;
            default: return 0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Commit rule: the last S+1 sampled mapped codes are identical and differ
    // from the held command. Repeats fire D cycles after a commit, then every P.
    int hist[$];
    int m_held = 0;
    int mq_code[$];
    int mq_rep[$];
    bit m_ovf = 0;
    bit pv = 0;
    int pc = 0;
    bit pr = 0;
    int since = 0;
    bit rep_ok = 0;
    bit nv, nr, all_eq;
    int nc, v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete(); hist.push_back(0);
            m_held = 0; mq_code.delete(); mq_rep.delete();
            m_ovf = 0; pv = 0; pc = 0; pr = 0; since = 0; rep_ok = 0;
        end else begin
            cyc++;
            if (mq_code.size() > 0 && cmd_if.cmd_ready) begin
                void'(mq_code.pop_front());
                void'(mq_rep.pop_front());
            end
            if (pv) begin
                if (mq_code.size() < DEPTH) begin
                    mq_code.push_back(pc);
                    mq_rep.push_back(int'(pr));
                end else begin
                    m_ovf = 1;
                end
            end
            nv = 0; nc = 0; nr = 0;
            v = hist[hist.size()-1];
            all_eq = (hist.size() == S + 1);
            foreach (hist[i]) if (hist[i] != v) all_eq = 0;
            if (all_eq && v != m_held) begin
                m_held = v;
                since = 0;
                if (v != 0) begin nv = 1; nc = v; end
`ifdef KEYCODE_AUTOREPEAT_EN
                rep_ok = (v != 0 && v != 6 && v != 7);
`else
                rep_ok = 0;
`endif
            end else if (rep_ok) begin
                since++;
                if (since == D || (since > D && (since - D) % P == 0)) begin
                    nv = 1; nc = m_held; nr = 1;
                end
            end
            pv = nv; pc = nc; pr = nr;
            hist.push_back(map_of(keycode));
            if (hist.size() > S + 1) void'(hist.pop_front());
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cmd_valid",  int'(cmd_if.cmd_valid),  int'(mq_code.size() > 0));
        check("cmd_code",   int'(cmd_if.cmd_code),   mq_code.size() > 0 ? mq_code[0] : 0);
        check("cmd_repeat", int'(cmd_if.cmd_repeat), mq_rep.size() > 0 ? mq_rep[0] : 0);
        check("key_held",   int'(key_held),          m_held);
        check("overflow",   int'(overflow),          int'(m_ovf));
        check("fifo_count", int'(fifo_count),        mq_code.size());
    end

    // Accepted events, with the cycle they were taken.
    int pop_code[$];
    int pop_rep[$];
    int pop_cyc[$];
    always @(posedge clk) begin
        if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            pop_code.push_back(int'(cmd_if.cmd_code));
            pop_rep.push_back(int'(cmd_if.cmd_repeat));
            pop_cyc.push_back(cyc);
        end
    end

    task automatic clear_pops();
        pop_code.delete(); pop_rep.delete(); pop_cyc.delete();
    endtask

    // Advance n edges, then settle to the drive point (+2 after the edge).
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [7:0] k, input int n);
        keycode = k;
        step(n);
    endtask

    function automatic int count_pops(input int code, input int rep);
        int c = 0;
        foreach (pop_code[i]) if (pop_code[i] == code && pop_rep[i] == rep) c++;
        return c;
    endfunction

    // Literal timing of a 0x1A press driven right now (at +2 after an edge).
    task automatic press_timing(input string tag);
        keycode = 8'h1A;
        repeat (5) @(posedge clk);
        #1 check({tag, "_held_e5"}, int'(key_held), 0);
        @(posedge clk);
        #1 check({tag, "_held_e6"}, int'(key_held), 1);
        check({tag, "_valid_e6"}, int'(cmd_if.cmd_valid), 0);
        @(posedge clk);
        #1 check({tag, "_valid_e7"}, int'(cmd_if.cmd_valid), 1);
        check({tag, "_code_e7"}, int'(cmd_if.cmd_code), 1);
        check({tag, "_rep_e7"}, int'(cmd_if.cmd_repeat), 0);
        @(posedge clk);
        #1 check({tag, "_valid_e8"}, int'(cmd_if.cmd_valid), 0);
        #1;
    endtask

    int first_dn, first_dn_rep;
    logic [7:0] codes [10];
    logic [7:0] ov_keys [6];

    initial begin
        rst = 1'b1;
        keycode = 8'h00;
        cmd_if.cmd_ready = 1'b1;
        step(3);
        #1 check("reset_valid", int'(cmd_if.cmd_valid), 0);
        check("reset_count", int'(fifo_count), 0);
        #1 rst = 1'b0;
        step(2);

        // Single press with literal latency.
        press_timing("press");
        hold(8'h00, 20);

        // Glitch shorter than the debounce window.
        clear_pops();
        hold(8'h04, 3);
        hold(8'h00, 20);
        check("glitch_held", int'(key_held), 0);
        check("glitch_events", pop_code.size(), 0);

        // Long hold of a repeatable key.
        clear_pops();
        hold(8'h07, 60);
        hold(8'h00, 20);
`ifdef KEYCODE_AUTOREPEAT_EN
        check("right_press", count_pops(4, 0), 1);
        check("right_repeats", count_pops(4, 1), 5);
        if (pop_cyc.size() >= 2) check("right_first_gap", pop_cyc[1] - pop_cyc[0], D);
        else check("right_first_gap_missing", pop_cyc.size(), 2);
`else
        check("right_press", count_pops(4, 0), 1);
        check("right_repeats", count_pops(4, 1), 0);
`endif

        // PAUSE never repeats.
        clear_pops();
        hold(8'h13, 40);
        hold(8'h00, 20);
        check("pause_events", pop_code.size(), 1);
        check("pause_press", count_pops(6, 0), 1);

        // Overflow with consumer stalled.
        cmd_if.cmd_ready = 1'b0;
        ov_keys = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h13};
        foreach (ov_keys[i]) begin
            hold(ov_keys[i], 8);
            hold(8'h00, 8);
        end
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_flag", int'(overflow), 1);
        clear_pops();
        cmd_if.cmd_ready = 1'b1;
        step(6);
        check("ovf_drained", pop_code.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < pop_code.size()) check("ovf_order", pop_code[i], i + 1);
        check("ovf_sticky", int'(overflow), 1);

        // Direct switch between two nonzero keys.
        clear_pops();
        hold(8'h1A, 30);
        hold(8'h16, 40);
        hold(8'h00, 20);
        check("switch_down_press", count_pops(2, 0), 1);
        first_dn = -1; first_dn_rep = -1;
        foreach (pop_code[i]) begin
            if (pop_code[i] == 2 && pop_rep[i] == 0 && first_dn < 0) first_dn = pop_cyc[i];
            if (pop_code[i] == 2 && pop_rep[i] == 1 && first_dn_rep < 0) first_dn_rep = pop_cyc[i];
        end
`ifdef KEYCODE_AUTOREPEAT_EN
        check("switch_repeat_gap", first_dn_rep - first_dn, D);
`else
        check("switch_no_repeat", count_pops(2, 1), 0);
`endif

        // Reset mid-hold with events queued.
        cmd_if.cmd_ready = 1'b0;
        hold(8'h1A, 8);
        hold(8'h00, 8);
        hold(8'h16, 8);
        hold(8'h00, 8);
        check("pre_reset_count", int'(fifo_count), 2);
        hold(8'h1A, 10);
        rst = 1'b1;
        #1;
        check("rst_valid", int'(cmd_if.cmd_valid), 0);
        check("rst_code", int'(cmd_if.cmd_code), 0);
        check("rst_repeat", int'(cmd_if.cmd_repeat), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_count", int'(fifo_count), 0);
        step(2);
        cmd_if.cmd_ready = 1'b1;
        rst = 1'b0;
        press_timing("rerelease");
        hold(8'h00, 20);

        // Randomized holds and back-pressure, checked by the model every cycle.
        codes = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h13, 8'h15, 8'h55, 8'h05};
        for (int it = 0; it < 60; it++) begin
            int len;
            keycode = codes[$urandom_range(0, 9)];
            len = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
                step(1);
            end
        end
        cmd_if.cmd_ready = 1'b1;
        hold(8'h00, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
